// File: rtl/sum_of_n_if.sv
// sum_of_n_if: operand/result bundle for sum_of_n; master drives N, slave returns S and done.
interface sum_of_n_if #(parameter int N_W = 4, parameter int S_W = 8);
  logic [N_W-1:0] N;
  logic [S_W-1:0] S;
  logic           done;
  modport master(output N, input S, done);
  modport slave(input N, output S, done);
endinterface

// File: rtl/sum_of_n.sv
// sum_of_n: registered 1+2+...+N, one addition per cycle; SUM_OF_N_CLOSED_FORM_EN loads N*(N+1)/2 in one edge.
module sum_of_n #(
  parameter int N_W = 4,
  parameter int S_W = 8
) (
  input logic       clk,
  input logic       rst,
  sum_of_n_if.slave bus
);
  logic [N_W-1:0] n_q, n_d;
  logic [N_W:0]   k_q, k_d;
  logic [S_W-1:0] acc_q, acc_d;
  logic           done_q, done_d;
`ifdef SUM_OF_N_CLOSED_FORM_EN
  logic [S_W:0]   prod;
  assign prod = (S_W+1)'(bus.N) * ((S_W+1)'(bus.N) + (S_W+1)'(1));
`endif
  always_comb begin
    n_d = n_q;
    k_d = k_q;
    acc_d = acc_q;
    done_d = done_q;
    if (bus.N != n_q) begin
      n_d = bus.N;
      k_d = (N_W+1)'(1);
`ifdef SUM_OF_N_CLOSED_FORM_EN
      acc_d = prod[S_W:1];
      done_d = 1'b1;
`else
      acc_d = '0;
      done_d = bus.N == '0;
`endif
    end else if (!done_q) begin
      acc_d = acc_q + S_W'(k_q);
      done_d = k_q == {1'b0, n_q};
      k_d = done_d ? k_q : k_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= '0;
      k_q <= '0;
      acc_q <= '0;
      done_q <= 1'b1;
    end else begin
      n_q <= n_d;
      k_q <= k_d;
      acc_q <= acc_d;
      done_q <= done_d;
    end
  end
  assign bus.S = acc_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_sum_of_n.sv
// tb_sum_of_n: directed and random stimulus against an arithmetic-series reference model.
module tb_sum_of_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int mn = 0;
  int c = 0;
  sum_of_n_if #(.N_W(4), .S_W(8)) bus ();
  sum_of_n #(.N_W(4), .S_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input int n, input string tag);
    int m;
    @(negedge clk);
    rst = r;
    bus.N = 4'(n);
    @(posedge clk);
    if (r) begin
      mn = 0;
      c = 0;
    end else if (n != mn) begin
      mn = n;
      c = 0;
    end else if (c < mn) c++;
`ifdef SUM_OF_N_CLOSED_FORM_EN
    m = mn;
`else
    m = c < mn ? c : mn;
`endif
    #1;
    chk({tag, ".S"}, int'(bus.S), m * (m + 1) / 2);
    chk({tag, ".done"}, int'(bus.done), int'(m == mn));
  endtask
  initial begin
    bus.N = '0;
    step(1, 0, "reset");
    step(1, 5, "reset_n5");
    for (int i = 0; i < 8; i++) step(0, 5, "n5");
    step(1, 0, "rst2");
    for (int i = 0; i < 18; i++) step(0, 15, "n15");
    step(1, 0, "rst3");
    for (int i = 0; i < 3; i++) step(0, 0, "n0");
    for (int i = 0; i < 3; i++) step(0, 1, "n1");
    for (int i = 0; i < 3; i++) step(0, 5, "n5b");
    for (int i = 0; i < 6; i++) step(0, 3, "switch3");
    for (int i = 0; i < 4; i++) step(0, 7, "n7");
    step(1, 7, "midrst");
    for (int i = 0; i < 10; i++) step(0, 7, "n7b");
    for (int i = 0; i < 600; i++) begin
      int n;
      n = $urandom_range(19) == 0 ? int'($urandom_range(15)) : mn;
      step(1'($urandom_range(39) == 0), n, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
